// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: steps one CNN inference through load, conv/pool and FC layers,
// with a zero-code settle gap between layers and a per-layer watchdog.
module cnn_layer_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 65535,
  parameter int WDT_W         = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_img_loaded,
  input  logic [7:0]  i_return_ctrl,
  output logic [7:0]  o_ctrl,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [2:0]  o_err_layer,
  output logic [31:0] o_total_cycles
);
  localparam int GW = $clog2(SETTLE_CYCLES + 1);
  // Layer states hold their ctrl code in the low bits; bit 3 marks the zero-code states.
  typedef enum logic [3:0] {
    IDLE = 4'd0, LOAD = 4'd1, CONV1 = 4'd2, POOL1 = 4'd3, CONV2 = 4'd4,
    POOL2 = 4'd5, FC = 4'd6, GAP = 4'd8, DONE = 4'd9, ERR = 4'd10
  } state_t;
  state_t           r_state, r_next;
  logic [WDT_W-1:0] r_wdt;
  logic [GW-1:0]    r_gap;
  logic             r_busy, r_done, r_error;
  logic [2:0]       r_err_layer;
  logic [31:0]      r_total;
  logic [2:0]       w_code;
  logic             w_cmp, w_expire;
  assign w_code = r_state[3] ? 3'd0 : r_state[2:0];
  // A zero watchdog means first cycle in the layer, where a stale echo must not count.
  assign w_cmp = (r_state == LOAD) ? (i_img_loaded && i_return_ctrl == 8'd1)
                                   : (r_wdt != '0 && i_return_ctrl == {5'd0, w_code});
  assign w_expire = r_wdt == WDT_W'(TIMEOUT - 1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_next      <= IDLE;
      r_wdt       <= '0;
      r_gap       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_layer <= '0;
      r_total     <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_busy && r_total != '1) r_total <= r_total + 32'd1;
      if (i_abort && r_busy) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (i_start && !i_abort) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
            r_total <= '0;
            r_wdt   <= '0;
          end
          LOAD, CONV1, POOL1, CONV2, POOL2, FC:
            if (w_cmp) begin
              r_state <= (r_state == FC) ? DONE : GAP;
              r_next  <= state_t'(r_state + 4'd1);
              r_gap   <= '0;
              r_busy  <= r_state != FC;
              r_done  <= r_state == FC;
            end else if (w_expire) begin
              r_state     <= ERR;
              r_error     <= 1'b1;
              r_err_layer <= w_code;
              r_busy      <= 1'b0;
            end else begin
              r_wdt <= r_wdt + WDT_W'(1);
            end
          GAP:
            if (r_gap == GW'(SETTLE_CYCLES - 1)) begin
              r_state <= r_next;
              r_wdt   <= '0;
            end else begin
              r_gap <= r_gap + GW'(1);
            end
          DONE: r_state <= IDLE;
          ERR: if (i_abort) begin
            r_state     <= IDLE;
            r_error     <= 1'b0;
            r_err_layer <= '0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  assign o_ctrl         = {5'd0, w_code};
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_err_layer    = r_err_layer;
  assign o_total_cycles = r_total;
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: randomized inference runs checked against a per-cycle ctrl plan
// derived from layer durations, gap length and watchdog limit.
module tb_cnn_layer_sequencer;
  localparam int S  = 2;
  localparam int TO = 16;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, img = 1'b0;
  logic [7:0]  ret = 8'h0;
  logic [7:0]  ctrl;
  logic        busy, done, error;
  logic [2:0]  err_layer;
  logic [31:0] total;
  int          checks = 0, errors = 0;
  int          dly[7];
  int          hang = 0;
  int          age = 0;
  logic [7:0]  last_ctrl = 8'h0;
  int          exp_q[$];

  always #5 clk = ~clk;

  cnn_layer_sequencer #(.SETTLE_CYCLES(S), .TIMEOUT(TO), .WDT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_img_loaded(img), .i_return_ctrl(ret), .o_ctrl(ctrl), .o_busy(busy),
    .o_done(done), .o_error(error), .o_err_layer(err_layer), .o_total_cycles(total)
  );

  // Layer-controller model: echoes a code once it has been on ctrl for dly[code] cycles.
  task automatic step();
    age = (ctrl == last_ctrl) ? age + 1 : 1;
    last_ctrl = ctrl;
    img = (ctrl == 8'd1 && age == dly[1]);
    if (ctrl == 8'd0) ret = 8'($urandom_range(0, 7));
    else if (ctrl == 8'd1) ret = 8'd1;
    else ret = (int'(ctrl) != hang && age >= dly[ctrl]) ? ctrl : 8'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic pick();
    dly[0] = 0;
    dly[1] = $urandom_range(1, 6);
    for (int c = 2; c < 7; c++) dly[c] = $urandom_range(1, 12);
  endtask

  // Expected ctrl per busy cycle: LOAD lasts dly[1], each later layer max(dly,2) after S zeros.
  task automatic plan(input int last);
    exp_q.delete();
    repeat (dly[1]) exp_q.push_back(1);
    for (int c = 2; c <= last; c++) begin
      repeat (S) exp_q.push_back(0);
      repeat (dly[c] < 2 ? 2 : dly[c]) exp_q.push_back(c);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ctrl, busy, done, error, err_layer, total} !== '0) begin
      errors++;
      $display("FAIL reset_values: got ctrl=%0d busy=%b done=%b error=%b err_layer=%0d total=%0d want all 0",
               ctrl, busy, done, error, err_layer, total);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (ctrl !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got ctrl=%0d busy=%b want 0 0", ctrl, busy);
    end
  endtask

  task automatic test_nominal();
    hang = 0;
    dly[1] = 3;
    for (int c = 2; c < 7; c++) dly[c] = 5;
    plan(6);
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (total !== 32'd0) begin errors++; $display("FAIL nominal_total_clear: got %0d want 0", total); end
    foreach (exp_q[i]) begin
      checks++;
      if (ctrl !== 8'(exp_q[i]) || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL nominal_seq[%0d]: got ctrl=%0d busy=%b done=%b want ctrl=%0d busy=1 done=0", i, ctrl, busy, done, exp_q[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ctrl !== 8'd0) begin
      errors++;
      $display("FAIL nominal_done: got done=%b busy=%b ctrl=%0d want 1 0 0", done, busy, ctrl);
    end
    checks++;
    if (total !== 32'(exp_q.size())) begin errors++; $display("FAIL nominal_total: got %0d want %0d", total, exp_q.size()); end
    step();
    checks++;
    if (done !== 1'b0 || total !== 32'(exp_q.size())) begin
      errors++;
      $display("FAIL nominal_done_once: got done=%b total=%0d want 0 %0d", done, total, exp_q.size());
    end
  endtask

  task automatic test_stale();
    hang = 0;
    pick();
    dly[2] = 1;
    plan(6);
    start = 1'b1; step(); start = 1'b0;
    foreach (exp_q[i]) begin
      checks++;
      if (ctrl !== 8'(exp_q[i]) || busy !== 1'b1) begin
        errors++;
        $display("FAIL stale_seq[%0d]: got ctrl=%0d busy=%b want ctrl=%0d busy=1", i, ctrl, busy, exp_q[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || total !== 32'(exp_q.size())) begin
      errors++;
      $display("FAIL stale_done: got done=%b total=%0d want 1 %0d", done, total, exp_q.size());
    end
    step();
  endtask

  task automatic test_back_to_back();
    hang = 0;
    for (int r = 0; r < 4; r++) begin
      pick();
      plan(6);
      start = 1'b1; step(); start = 1'b0;
      foreach (exp_q[i]) begin
        checks++;
        if (ctrl !== 8'(exp_q[i]) || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL b2b%0d_seq[%0d]: got ctrl=%0d busy=%b done=%b want ctrl=%0d busy=1 done=0", r, i, ctrl, busy, done, exp_q[i]);
        end
        start = ($urandom_range(0, 3) == 0);
        step();
        start = 1'b0;
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || total !== 32'(exp_q.size())) begin
        errors++;
        $display("FAIL b2b%0d_done: got done=%b busy=%b total=%0d want 1 0 %0d", r, done, busy, total, exp_q.size());
      end
      step();
    end
  endtask

  task automatic test_timeout();
    pick();
    hang = 4;
    plan(3);
    repeat (S) exp_q.push_back(0);
    repeat (TO) exp_q.push_back(4);
    start = 1'b1; step(); start = 1'b0;
    foreach (exp_q[i]) begin
      checks++;
      if (ctrl !== 8'(exp_q[i]) || busy !== 1'b1 || error !== 1'b0) begin
        errors++;
        $display("FAIL timeout_seq[%0d]: got ctrl=%0d busy=%b error=%b want ctrl=%0d busy=1 error=0", i, ctrl, busy, error, exp_q[i]);
      end
      step();
    end
    checks++;
    if (error !== 1'b1 || err_layer !== 3'd4 || ctrl !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: got error=%b err_layer=%0d ctrl=%0d busy=%b done=%b want 1 4 0 0 0", error, err_layer, ctrl, busy, done);
    end
    checks++;
    if (total !== 32'(exp_q.size())) begin errors++; $display("FAIL timeout_total: got %0d want %0d", total, exp_q.size()); end
    start = 1'b1; step(); start = 1'b0;
    step();
    checks++;
    if (error !== 1'b1 || ctrl !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_start_ignored: got error=%b ctrl=%0d busy=%b want 1 0 0", error, ctrl, busy);
    end
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if (error !== 1'b0 || err_layer !== 3'd0 || ctrl !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort_clear: got error=%b err_layer=%0d ctrl=%0d busy=%b want 0 0 0 0", error, err_layer, ctrl, busy);
    end
    hang = 0;
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (ctrl !== 8'd1 || busy !== 1'b1) begin errors++; $display("FAIL timeout_restart: got ctrl=%0d busy=%b want 1 1", ctrl, busy); end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_abort();
    int d3, k;
    hang = 0;
    pick();
    plan(2);
    d3 = dly[3] < 2 ? 2 : dly[3];
    k = $urandom_range(1, d3);
    repeat (S) exp_q.push_back(0);
    repeat (k) exp_q.push_back(3);
    start = 1'b1; step(); start = 1'b0;
    foreach (exp_q[i]) begin
      checks++;
      if (ctrl !== 8'(exp_q[i]) || busy !== 1'b1) begin
        errors++;
        $display("FAIL abort_seq[%0d]: got ctrl=%0d busy=%b want ctrl=%0d busy=1", i, ctrl, busy, exp_q[i]);
      end
      abort = (i == exp_q.size() - 1);
      step();
    end
    abort = 1'b0;
    checks++;
    if (ctrl !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || total !== 32'(exp_q.size())) begin
      errors++;
      $display("FAIL abort_stop: got ctrl=%0d busy=%b done=%b total=%0d want 0 0 0 %0d", ctrl, busy, done, total, exp_q.size());
    end
    for (int j = 0; j < 3; j++) begin
      step();
      checks++;
      if (done !== 1'b0 || ctrl !== 8'd0 || total !== 32'(exp_q.size())) begin
        errors++;
        $display("FAIL abort_quiet[%0d]: got done=%b ctrl=%0d total=%0d want 0 0 %0d", j, done, ctrl, total, exp_q.size());
      end
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (ctrl !== 8'd1 || busy !== 1'b1 || total !== 32'd0) begin
      errors++;
      $display("FAIL abort_restart: got ctrl=%0d busy=%b total=%0d want 1 1 0", ctrl, busy, total);
    end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_contention();
    hang = 0;
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if (ctrl !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL idle_abort: got ctrl=%0d busy=%b want 0 0", ctrl, busy); end
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    checks++;
    if (ctrl !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL start_abort: got ctrl=%0d busy=%b want 0 0", ctrl, busy); end
    step();
    checks++;
    if (ctrl !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL start_abort_hold: got ctrl=%0d busy=%b want 0 0", ctrl, busy); end
    pick();
    plan(6);
    start = 1'b1; step();
    foreach (exp_q[i]) begin
      checks++;
      if (ctrl !== 8'(exp_q[i]) || busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_start_seq[%0d]: got ctrl=%0d busy=%b want ctrl=%0d busy=1", i, ctrl, busy, exp_q[i]);
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || total !== 32'(exp_q.size())) begin
      errors++;
      $display("FAIL busy_start_done: got done=%b total=%0d want 1 %0d", done, total, exp_q.size());
    end
    step();
  endtask

  task automatic test_async_reset();
    hang = 0;
    pick();
    plan(6);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < exp_q.size() - 1; i++) begin
      checks++;
      if (ctrl !== 8'(exp_q[i])) begin
        errors++;
        $display("FAIL areset_seq[%0d]: got ctrl=%0d want %0d", i, ctrl, exp_q[i]);
      end
      step();
    end
    checks++;
    if (ctrl !== 8'd6 || busy !== 1'b1) begin errors++; $display("FAIL areset_in_fc: got ctrl=%0d busy=%b want 6 1", ctrl, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || total !== 32'd0) begin
      errors++;
      $display("FAIL areset_immediate: got ctrl=%0d busy=%b done=%b total=%0d want 0 0 0 0", ctrl, busy, done, total);
    end
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (ctrl !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL areset_release: got ctrl=%0d busy=%b done=%b want 0 0 0", ctrl, busy, done);
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (ctrl !== 8'd1 || busy !== 1'b1) begin errors++; $display("FAIL areset_restart: got ctrl=%0d busy=%b want 1 1", ctrl, busy); end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stale();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_contention();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no completion want finish before 1000000");
    $fatal(1, "bench did not complete");
  end
endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
- Sequences one full inference through the CNN layer controller: image load, conv1, pool1, conv2, pool2, FC.
- Drives the 8-bit layer code `ctrl` into the layer controller and watches its `return_ctrl` completion echo.
- Inserts a settle gap of `ctrl`=0 between layers so all memory address counters are held in reset. Guards each layer with a watchdog.
- Sits between the host register interface and the layer controller.

Parameters:
- SETTLE_CYCLES, 2, cycles `ctrl` is held at 0 between layers (>=1).
- TIMEOUT, 65535, max cycles allowed in one layer state before error.
- WDT_W, 16, watchdog counter width (must hold TIMEOUT).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to run one inference
- abort  in  1  single-cycle request to stop and return to IDLE
- img_loaded  in  1  host pulse: image memory fully written
- return_ctrl  in  8  completion echo from the layer controller
- ctrl  out  8  layer code to the layer controller
- busy  out  1  high from accepted start until DONE or ERR
- done  out  1  one-cycle pulse on FC completion
- error  out  1  sticky watchdog error flag
- err_layer  out  3  layer code (low 3 bits) that timed out
- total_cycles  out  32  cycles from start accept to done, frozen after done

Behaviour:
- Reset (reset=0, async): state=IDLE, ctrl=0, busy=0, done=0, error=0, err_layer=0, total_cycles=0, watchdog=0, gap counter=0.
- All outputs are registered. `ctrl` is a function of the registered state.
- States and their `ctrl` codes: IDLE(0), LOAD(1), CONV1(2), POOL1(3), CONV2(4), POOL2(5), FC(6), GAP(0), DONE(0), ERR(0).
- IDLE:
  - start=1 -> LOAD next cycle; busy=1, total_cycles cleared to 0.
  - start while busy is ignored.
- LOAD: when img_loaded=1 and return_ctrl=1 in the same cycle -> GAP, with next=CONV1.
- Layer states CONV1..FC:
  - Completion is return_ctrl equal to the state's code, sampled no earlier than the second cycle in the state. The first cycle is masked to reject stale echoes.
  - On completion: CONV1->GAP(next POOL1), POOL1->GAP(next CONV2), CONV2->GAP(next POOL2), POOL2->GAP(next FC), FC->DONE.
- GAP:
  - ctrl=0 for exactly SETTLE_CYCLES cycles, then enter the stored next state.
  - return_ctrl is ignored during GAP.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. total_cycles holds its value until the next accepted start.
- Watchdog:
  - Cleared on entry to each layer state, including LOAD.
  - Increments every cycle in that state.
  - When it reaches TIMEOUT without completion -> ERR: error=1, err_layer=ctrl[2:0] of the failing layer, busy=0.
  - The watchdog is not active in GAP, IDLE, DONE or ERR.
- ERR:
  - Holds ctrl=0.
  - start is ignored.
  - abort -> IDLE and clears error and err_layer.
- abort in any busy state:
  - Next cycle: state=IDLE, ctrl=0, busy=0, done=0.
  - total_cycles freezes at its current value.
  - abort in IDLE has no effect.
- Simultaneous events:
  - start and abort in the same cycle: abort wins, no run starts.
  - Completion and watchdog expiry in the same cycle: completion wins.
  - abort and completion in the same cycle: abort wins.
- total_cycles:
  - Increments every cycle while busy=1. It counts the LOAD entry cycle through the FC completion cycle.
  - Saturates at all-ones.
- Reset mid-run: immediate return to the reset values. The layer controller sees ctrl=0 and therefore holds all memories in reset.

Test Plan:
- Nominal run (SETTLE_CYCLES=2):
  - Stimulus: start; img_loaded 3 cycles later; model returns each code 5 cycles after its entry.
  - Required `ctrl` sequence: 1, 0,0, 2, 0,0, 3, 0,0, 4, 0,0, 5, 0,0, 6, then 0.
  - Required response: done pulses once, busy drops the same cycle, total_cycles equals the counted cycles.
- Stale echo: return_ctrl=2 already high on the CONV1 entry cycle -> ignored; CONV1 exits on the second cycle, not the first.
- Timeout (TIMEOUT=16): model never echoes 4 in CONV2 -> after 16 cycles error=1, err_layer=4, ctrl=0, busy=0. start is then ignored; abort -> IDLE and error=0.
- Abort mid-layer: abort during POOL1 -> next cycle ctrl=0, busy=0, no done. A later start restarts at LOAD.
- Contention:
  - start+abort same cycle in IDLE -> stays IDLE.
  - start during CONV1 -> no effect on the sequence.
- Async reset: assert reset=0 mid-FC between clock edges -> ctrl=0, busy=0 immediately (no clock edge); after release, the block is in IDLE.
